// File: rtl/nileswan_pkg.sv
// Shared types for the MCU SPI bus arbiter: FSM state encoding, bus owner
// identity and the round-robin pick used when the bus is free.
package nileswan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RTC  = 2'd1,
    ST_HOST = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_RTC  = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

  // Choose the next owner from idle; on a tie the master that did not own
  // the bus last time wins, so neither side can starve the other.
  function automatic arb_state_e arb_pick(input logic rtc_req,
                                          input logic host_req,
                                          input owner_e last_owner);
    arb_state_e pick;
    if (rtc_req && host_req) begin
      pick = (last_owner == OWNER_HOST) ? ST_RTC : ST_HOST;
    end else if (rtc_req) begin
      pick = ST_RTC;
    end else if (host_req) begin
      pick = ST_HOST;
    end else begin
      pick = ST_IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mcu_spi_arbiter_if.sv
// Bundle of the two master-side SPI engines, the error handshake and the
// physical MCU SPI pins. The arbiter uses the slave view; the environment
// (engines, pads) uses the master view.
interface mcu_spi_arbiter_if;
  logic RtcReq, RtcGrant, RtcClkRunning, RtcClkStretch, RtcDo, RtcnSel, RtcDi, RtcAbort;
  logic HostReq, HostGrant, HostClkRunning, HostDo, HostnSel, HostDi;
  logic ErrClr, TimeoutErr;
  logic SPIClk, SPIDo, SPIDi, nMCUSel;

  modport slave (
    input  RtcReq, RtcClkRunning, RtcClkStretch, RtcDo, RtcnSel,
    output RtcGrant, RtcDi, RtcAbort,
    input  HostReq, HostClkRunning, HostDo, HostnSel,
    output HostGrant, HostDi,
    input  ErrClr,
    output TimeoutErr,
    output SPIClk, SPIDo, nMCUSel,
    input  SPIDi
  );

  modport master (
    output RtcReq, RtcClkRunning, RtcClkStretch, RtcDo, RtcnSel,
    input  RtcGrant, RtcDi, RtcAbort,
    output HostReq, HostClkRunning, HostDo, HostnSel,
    input  HostGrant, HostDi,
    output ErrClr,
    input  TimeoutErr,
    input  SPIClk, SPIDo, nMCUSel,
    output SPIDi
  );
endinterface

// File: rtl/spi_clk_gate.sv
// Glitch-free SPI clock gate: the enable is captured while the bit clock is
// low, so the AND below can only open or close between full clock pulses.
module spi_clk_gate (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic gclk
);

  logic en_lat_q;

  // Capture the enable on the falling edge; reset closes the gate at once.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      en_lat_q <= 1'b0;
    end else begin
      en_lat_q <= en;
    end
  end

  assign gclk = clk & en_lat_q;

endmodule

// File: rtl/mcu_spi_arbiter.sv
// Arbiter for the single MCU SPI bus shared by the RTC command engine and the
// host SPI engine: round-robin ownership, chip-select gap between owners,
// pin muxing, MISO return routing and an RTC clock-stretch watchdog.
module mcu_spi_arbiter
  import nileswan_pkg::*;
#(
  parameter int GAP_CYCLES      = 2,
  parameter int STRETCH_TIMEOUT = 1023,
  parameter int CNT_W           = 16
) (
  input  logic              SClk,
  input  logic              Reset,
  mcu_spi_arbiter_if.slave  bus
);

  localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(STRETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1    = CNT_W'(STRETCH_TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  owner_e           last_owner_q, last_owner_d;
  logic             rtc_grant_q, rtc_grant_d;
  logic             host_grant_q, host_grant_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] stretch_cnt_q, stretch_cnt_d;
  logic             aborted_q, aborted_d;
  logic             abort_pulse_q, abort_pulse_d;
  logic             timeout_err_q, timeout_err_d;
  logic             wd_fire;
  logic             clk_en;

  // State register and all other flops; reset returns the bus to idle.
  always_ff @(posedge SClk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      last_owner_q  <= OWNER_HOST;
      rtc_grant_q   <= 1'b0;
      host_grant_q  <= 1'b0;
      gap_cnt_q     <= 4'd0;
      stretch_cnt_q <= '0;
      aborted_q     <= 1'b0;
      abort_pulse_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      rtc_grant_q   <= rtc_grant_d;
      host_grant_q  <= host_grant_d;
      gap_cnt_q     <= gap_cnt_d;
      stretch_cnt_q <= stretch_cnt_d;
      aborted_q     <= aborted_d;
      abort_pulse_q <= abort_pulse_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic: arbitration from idle, release detection, CS gap timing.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        gap_cnt_d = 4'd0;
        state_d   = arb_pick(bus.RtcReq, bus.HostReq, last_owner_q);
      end
      ST_RTC: begin
        // After an abort the engine may still hold its select low; dropping
        // the request alone is then enough to release.
        if (!bus.RtcReq && (bus.RtcnSel || aborted_q)) begin
          state_d      = ST_GAP;
          last_owner_d = OWNER_RTC;
          gap_cnt_d    = 4'd0;
        end else begin
          state_d = ST_RTC;
        end
      end
      ST_HOST: begin
        if (!bus.HostReq && bus.HostnSel) begin
          state_d      = ST_GAP;
          last_owner_d = OWNER_HOST;
          gap_cnt_d    = 4'd0;
        end else begin
          state_d = ST_HOST;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q >= GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = 4'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rtc_grant_d  = (state_d == ST_RTC);
    host_grant_d = (state_d == ST_HOST);
  end

  // Stretch watchdog and sticky timeout flag; fires once per RTC ownership.
  always_comb begin
    stretch_cnt_d = '0;
    aborted_d     = 1'b0;
    wd_fire       = 1'b0;
    if (state_q == ST_RTC) begin
      wd_fire   = bus.RtcClkStretch && !aborted_q && (stretch_cnt_q == TO_M1);
      aborted_d = aborted_q | wd_fire;
      if (bus.RtcClkStretch) begin
        stretch_cnt_d = (stretch_cnt_q == TO_VAL) ? stretch_cnt_q : stretch_cnt_q + CNT_W'(1);
      end else begin
        stretch_cnt_d = '0;
      end
    end else begin
      stretch_cnt_d = '0;
    end
    abort_pulse_d = wd_fire;
    if (wd_fire) begin
      timeout_err_d = 1'b1;
    end else if (bus.ErrClr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // Output logic: pins follow the owner combinationally, idle otherwise.
  always_comb begin
    bus.SPIDo   = 1'b1;
    bus.nMCUSel = 1'b1;
    bus.RtcDi   = 1'b1;
    bus.HostDi  = 1'b1;
    clk_en      = 1'b0;
    case (state_q)
      ST_RTC: begin
        bus.RtcDi = bus.SPIDi;
        if (aborted_q) begin
          clk_en = 1'b0;
        end else begin
          bus.SPIDo   = bus.RtcDo;
          bus.nMCUSel = bus.RtcnSel;
          clk_en      = bus.RtcClkRunning & ~bus.RtcClkStretch;
        end
      end
      ST_HOST: begin
        bus.HostDi  = bus.SPIDi;
        bus.SPIDo   = bus.HostDo;
        bus.nMCUSel = bus.HostnSel;
        clk_en      = bus.HostClkRunning;
      end
      default: begin
        clk_en = 1'b0;
      end
    endcase
  end

  assign bus.RtcGrant   = rtc_grant_q;
  assign bus.HostGrant  = host_grant_q;
  assign bus.RtcAbort   = abort_pulse_q;
  assign bus.TimeoutErr = timeout_err_q;

  spi_clk_gate u_clk_gate (
    .clk  (SClk),
    .rst  (Reset),
    .en   (clk_en),
    .gclk (bus.SPIClk)
  );

endmodule

// File: tb/tb_mcu_spi_arbiter.sv
// Bench for the MCU SPI arbiter: one task per scenario, MOSI bits scored
// through an expected queue filled while driving and an observed queue filled
// on every SPIClk rising edge.
module tb_mcu_spi_arbiter;

  localparam int GAP = 2;
  localparam int TO  = 1023;

  logic SClk  = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic obs_q[$];

  mcu_spi_arbiter_if bus();

  mcu_spi_arbiter #(.GAP_CYCLES(GAP), .STRETCH_TIMEOUT(TO), .CNT_W(16)) dut (
    .SClk  (SClk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 SClk = ~SClk;

  always @(posedge bus.SPIClk) obs_q.push_back(bus.SPIDo);

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge SClk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.RtcReq = 1'b0; bus.RtcClkRunning = 1'b0; bus.RtcClkStretch = 1'b0; bus.RtcDo = 1'b1; bus.RtcnSel = 1'b1;
    bus.HostReq = 1'b0; bus.HostClkRunning = 1'b0; bus.HostDo = 1'b1; bus.HostnSel = 1'b1;
    bus.ErrClr = 1'b0; bus.SPIDi = 1'b1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Shift one byte MSB first from the chosen engine, recording expected bits.
  task automatic send_byte(input bit is_rtc, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (is_rtc) begin bus.RtcDo = b[i]; bus.RtcClkRunning = 1'b1; end
      else begin bus.HostDo = b[i]; bus.HostClkRunning = 1'b1; end
      exp_q.push_back(b[i]);
      tick();
    end
    bus.RtcClkRunning = 1'b0; bus.HostClkRunning = 1'b0;
    bus.RtcDo = 1'b1; bus.HostDo = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    bus.SPIDi = 1'b0;
    bus.HostnSel = 1'b0;
    bus.HostDo = 1'b0;
    #1;
    checks++; if (bus.RtcGrant !== 1'b0) begin errors++; $display("FAIL rst_rtc_grant got %b want 0", bus.RtcGrant); end
    checks++; if (bus.HostGrant !== 1'b0) begin errors++; $display("FAIL rst_host_grant got %b want 0", bus.HostGrant); end
    checks++; if (bus.SPIClk !== 1'b0) begin errors++; $display("FAIL rst_spiclk got %b want 0", bus.SPIClk); end
    checks++; if (bus.SPIDo !== 1'b1) begin errors++; $display("FAIL rst_spido got %b want 1", bus.SPIDo); end
    checks++; if (bus.nMCUSel !== 1'b1) begin errors++; $display("FAIL rst_nsel got %b want 1", bus.nMCUSel); end
    checks++; if (bus.TimeoutErr !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got %b want 0", bus.TimeoutErr); end
    checks++; if (bus.RtcAbort !== 1'b0) begin errors++; $display("FAIL rst_abort got %b want 0", bus.RtcAbort); end
    checks++; if ({bus.RtcDi, bus.HostDi} !== 2'b11) begin errors++; $display("FAIL rst_di got %b want 11", {bus.RtcDi, bus.HostDi}); end
    idle_inputs();
  endtask

  task automatic test_rtc_grant();
    logic e, o;
    obs_q.delete(); exp_q.delete();
    bus.RtcReq = 1'b1;
    #1;
    checks++; if (bus.RtcGrant !== 1'b0) begin errors++; $display("FAIL grant_latency got %b want 0", bus.RtcGrant); end
    tick();
    checks++; if (bus.RtcGrant !== 1'b1 || bus.HostGrant !== 1'b0) begin errors++; $display("FAIL rtc_grant got %b%b want 10", bus.RtcGrant, bus.HostGrant); end
    bus.RtcnSel = 1'b0; bus.RtcDo = 1'b0; bus.SPIDi = 1'b0;
    #1;
    checks++; if ({bus.nMCUSel, bus.SPIDo} !== 2'b00) begin errors++; $display("FAIL rtc_pins got %b want 00", {bus.nMCUSel, bus.SPIDo}); end
    checks++; if ({bus.RtcDi, bus.HostDi} !== 2'b01) begin errors++; $display("FAIL rtc_miso got %b want 01", {bus.RtcDi, bus.HostDi}); end
    bus.SPIDi = 1'b1;
    send_byte(1'b1, 8'hA5);
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL rtc_pulses got %0d want 8", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("FAIL rtc_mosi got %b want %b", o, e); end
    end
    bus.RtcnSel = 1'b1; bus.RtcReq = 1'b0;
    tick();
    checks++; if (bus.RtcGrant !== 1'b0) begin errors++; $display("FAIL rtc_release got %b want 0", bus.RtcGrant); end
    repeat (GAP + 2) tick();
  endtask

  task automatic test_tie_round_robin();
    logic e, o;
    int   w;
    logic cs_low;
    idle_inputs();
    do_reset();
    obs_q.delete(); exp_q.delete();
    bus.RtcReq = 1'b1; bus.HostReq = 1'b1;
    tick();
    checks++; if ({bus.RtcGrant, bus.HostGrant} !== 2'b10) begin errors++; $display("FAIL tie_first got %b want 10", {bus.RtcGrant, bus.HostGrant}); end
    bus.RtcnSel = 1'b0;
    send_byte(1'b1, 8'h3C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("FAIL tie_rtc_mosi got %b want %b", o, e); end
    end
    bus.RtcnSel = 1'b1; bus.RtcReq = 1'b0;
    tick();
    w = 0; cs_low = 1'b0;
    while (bus.HostGrant !== 1'b1 && w < 20) begin
      if (bus.nMCUSel !== 1'b1) cs_low = 1'b1;
      tick();
      w++;
    end
    checks++; if (w != GAP + 1) begin errors++; $display("FAIL gap_cycles got %0d want %0d", w, GAP + 1); end
    checks++; if (cs_low !== 1'b0) begin errors++; $display("FAIL gap_cs got %b want 0", cs_low); end
    obs_q.delete();
    bus.HostnSel = 1'b0;
    send_byte(1'b0, 8'hC3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("FAIL tie_host_mosi got %b want %b", o, e); end
    end
    bus.HostnSel = 1'b1; bus.HostReq = 1'b0;
    repeat (GAP + 3) tick();
    bus.RtcReq = 1'b1; bus.HostReq = 1'b1;
    tick();
    checks++; if ({bus.RtcGrant, bus.HostGrant} !== 2'b10) begin errors++; $display("FAIL tie_second got %b want 10", {bus.RtcGrant, bus.HostGrant}); end
    bus.RtcReq = 1'b0; bus.HostReq = 1'b0;
    repeat (GAP + 3) tick();
  endtask

  task automatic test_host_hold();
    logic e, o;
    int   w;
    obs_q.delete(); exp_q.delete();
    bus.HostReq = 1'b1;
    tick();
    checks++; if (bus.HostGrant !== 1'b1) begin errors++; $display("FAIL host_grant got %b want 1", bus.HostGrant); end
    bus.HostnSel = 1'b0; bus.HostDo = 1'b1;
    bus.RtcReq = 1'b1; bus.RtcnSel = 1'b0; bus.RtcDo = 1'b0; bus.SPIDi = 1'b0;
    tick();
    checks++; if ({bus.nMCUSel, bus.SPIDo} !== 2'b01) begin errors++; $display("FAIL host_pins got %b want 01", {bus.nMCUSel, bus.SPIDo}); end
    checks++; if ({bus.RtcDi, bus.HostDi} !== 2'b10) begin errors++; $display("FAIL host_miso got %b want 10", {bus.RtcDi, bus.HostDi}); end
    bus.SPIDi = 1'b1;
    send_byte(1'b0, 8'h5A);
    bus.RtcDo = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("FAIL host_mosi got %b want %b", o, e); end
    end
    checks++; if ({bus.RtcGrant, bus.HostGrant} !== 2'b01) begin errors++; $display("FAIL no_preempt got %b want 01", {bus.RtcGrant, bus.HostGrant}); end
    bus.HostnSel = 1'b1; bus.HostReq = 1'b0; bus.RtcnSel = 1'b1; bus.RtcDo = 1'b1;
    tick();
    w = 0;
    while (bus.RtcGrant !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    checks++; if (w != GAP + 1) begin errors++; $display("FAIL pending_grant got %0d want %0d", w, GAP + 1); end
  endtask

  task automatic test_stretch_short();
    logic e, o;
    logic ab;
    obs_q.delete(); exp_q.delete();
    ab = 1'b0;
    bus.RtcnSel = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.RtcClkRunning = 1'b1;
      bus.RtcClkStretch = (i >= 3 && i < 8) ? 1'b1 : 1'b0;
      bus.RtcDo = (i % 2 == 0) ? 1'b1 : 1'b0;
      if (bus.RtcClkStretch == 1'b0) exp_q.push_back(bus.RtcDo);
      tick();
      if (bus.RtcAbort === 1'b1) ab = 1'b1;
    end
    bus.RtcClkRunning = 1'b0; bus.RtcClkStretch = 1'b0; bus.RtcDo = 1'b1;
    tick();
    tick();
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL stretch_pulses got %0d want 6", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("FAIL stretch_mosi got %b want %b", o, e); end
    end
    checks++; if ({ab, bus.TimeoutErr} !== 2'b00) begin errors++; $display("FAIL stretch_no_abort got %b want 00", {ab, bus.TimeoutErr}); end
  endtask

  task automatic test_watchdog();
    logic early;
    obs_q.delete();
    early = 1'b0;
    bus.RtcnSel = 1'b0; bus.RtcDo = 1'b0;
    bus.RtcClkRunning = 1'b1; bus.RtcClkStretch = 1'b1;
    for (int n = 1; n <= TO; n++) begin
      if (n == TO) bus.ErrClr = 1'b1;
      tick();
      if (n < TO && bus.RtcAbort === 1'b1) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL wd_early got %b want 0", early); end
    checks++; if (bus.RtcAbort !== 1'b1) begin errors++; $display("FAIL wd_abort got %b want 1", bus.RtcAbort); end
    checks++; if (bus.TimeoutErr !== 1'b1) begin errors++; $display("FAIL wd_set_wins got %b want 1", bus.TimeoutErr); end
    checks++; if ({bus.nMCUSel, bus.SPIDo} !== 2'b11) begin errors++; $display("FAIL wd_pins got %b want 11", {bus.nMCUSel, bus.SPIDo}); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL wd_clock got %0d want 0", obs_q.size()); end
    bus.ErrClr = 1'b0;
    tick();
    checks++; if ({bus.RtcAbort, bus.TimeoutErr, bus.RtcGrant} !== 3'b011) begin errors++; $display("FAIL wd_after got %b want 011", {bus.RtcAbort, bus.TimeoutErr, bus.RtcGrant}); end
    bus.ErrClr = 1'b1;
    tick();
    checks++; if (bus.TimeoutErr !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", bus.TimeoutErr); end
    bus.ErrClr = 1'b0;
    bus.RtcReq = 1'b0;
    tick();
    checks++; if (bus.RtcGrant !== 1'b0) begin errors++; $display("FAIL wd_release got %b want 0", bus.RtcGrant); end
    bus.RtcClkStretch = 1'b0; bus.RtcClkRunning = 1'b0; bus.RtcnSel = 1'b1; bus.RtcDo = 1'b1;
    repeat (GAP + 2) tick();
  endtask

  task automatic test_reset_mid();
    bus.RtcReq = 1'b1;
    tick();
    bus.RtcnSel = 1'b0; bus.RtcClkRunning = 1'b1;
    tick();
    checks++; if ({bus.SPIClk, bus.nMCUSel} !== 2'b10) begin errors++; $display("FAIL mid_pre got %b want 10", {bus.SPIClk, bus.nMCUSel}); end
    #1;
    Reset = 1'b1;
    #1;
    checks++; if ({bus.nMCUSel, bus.SPIClk, bus.RtcGrant, bus.HostGrant} !== 4'b1000) begin errors++; $display("FAIL mid_reset got %b want 1000", {bus.nMCUSel, bus.SPIClk, bus.RtcGrant, bus.HostGrant}); end
    bus.RtcReq = 1'b0; bus.RtcnSel = 1'b1; bus.RtcClkRunning = 1'b0; bus.HostReq = 1'b1;
    tick();
    checks++; if (bus.HostGrant !== 1'b0) begin errors++; $display("FAIL held_in_reset got %b want 0", bus.HostGrant); end
    Reset = 1'b0;
    tick();
    checks++; if ({bus.HostGrant, bus.RtcGrant} !== 2'b10) begin errors++; $display("FAIL post_reset_nogap got %b want 10", {bus.HostGrant, bus.RtcGrant}); end
    bus.HostReq = 1'b0;
    repeat (GAP + 3) tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_rtc_grant();
    test_tie_round_robin();
    test_host_hold();
    test_stretch_short();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
